// File: rtl/midi_parser.sv
// rtl/midi_parser.sv - MIDI channel-voice parser with running status and real-time passthrough.
// Optional build macro MIDI_CHANNEL_FILTER_EN: emit only messages on channel CHANNEL.
module midi_parser #(
   parameter int CHANNEL          = 0,
   parameter int NOTE_ON_ZERO_OFF = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       dv,
   input  logic [7:0] di,
   output logic       msg_valid,
   output logic [2:0] msg_cmd,
   output logic [3:0] msg_ch,
   output logic [6:0] msg_d1,
   output logic [6:0] msg_d2,
   output logic       rt_valid,
   output logic [7:0] rt_byte
);

`ifdef MIDI_CHANNEL_FILTER_EN
   localparam bit FILTER_ON = 1'b1;
`else
   localparam bit FILTER_ON = 1'b0;
`endif
   localparam logic [3:0] FILTER_CH = 4'(CHANNEL);
   localparam bit         VEL0_OFF  = (NOTE_ON_ZERO_OFF != 0);

   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

   state_t     state_q, state_d;
   logic [6:0] status_q, status_d;
   logic [6:0] d1_q, d1_d;
   logic       emit;
   logic [2:0] emit_cmd;
   logic [6:0] emit_d1, emit_d2;
   logic       chan_ok;

   logic accept, is_rt, is_chan, is_sysex, is_common, two_data;

   assign accept    = dv & ce;
   assign is_rt     = (di[7:3] == 5'b11111);
   assign is_chan   = di[7] & (di[6:4] != 3'b111);
   assign is_sysex  = (di == 8'hF0);
   assign is_common = (di[7:3] == 5'b11110) & (di[2:0] != 3'b000);
   assign two_data  = (status_q[6:4] != 3'b100) & (status_q[6:4] != 3'b101);
   assign chan_ok   = !FILTER_ON || (status_q[3:0] == FILTER_CH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         status_q <= '0;
         d1_q     <= '0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         d1_q     <= d1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      d1_d     = d1_q;
      emit     = 1'b0;
      emit_d1  = d1_q;
      emit_d2  = '0;
      emit_cmd = status_q[6:4];
      // Real-time bytes never disturb parsing state.
      if (accept && !is_rt) begin
         if (is_chan) begin
            status_d = di[6:0];
            state_d  = WAIT_D1;
         end else if (is_sysex) begin
            status_d = '0;
            state_d  = SYSEX;
         end else if (is_common) begin
            status_d = '0;
            state_d  = IDLE;
         end else begin
            case (state_q)
               WAIT_D1: begin
                  d1_d = di[6:0];
                  if (two_data) begin
                     state_d = WAIT_D2;
                  end else begin
                     emit    = 1'b1;
                     emit_d1 = di[6:0];
                  end
               end
               WAIT_D2: begin
                  emit    = 1'b1;
                  emit_d2 = di[6:0];
                  state_d = WAIT_D1;
               end
               default: ;
            endcase
         end
      end
      if (VEL0_OFF && emit_cmd == 3'b001 && emit_d2 == 7'd0)
         emit_cmd = 3'b000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_valid <= 1'b0;
         msg_cmd   <= '0;
         msg_ch    <= '0;
         msg_d1    <= '0;
         msg_d2    <= '0;
         rt_valid  <= 1'b0;
         rt_byte   <= '0;
      end else begin
         msg_valid <= emit & chan_ok;
         if (emit && chan_ok) begin
            msg_cmd <= emit_cmd;
            msg_ch  <= status_q[3:0];
            msg_d1  <= emit_d1;
            msg_d2  <= emit_d2;
         end
         rt_valid <= accept & is_rt;
         if (accept && is_rt)
            rt_byte <= di;
      end
   end

endmodule

// File: tb/tb_midi_parser.sv
// tb/tb_midi_parser.sv - Directed and randomized byte-stream bench for midi_parser against a message-level model.
module tb_midi_parser;

   localparam int CHANNEL          = 2;
   localparam int NOTE_ON_ZERO_OFF = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b0;
   logic       dv = 1'b0;
   logic [7:0] di = 8'h00;
   logic       msg_valid, rt_valid;
   logic [2:0] msg_cmd;
   logic [3:0] msg_ch;
   logic [6:0] msg_d1, msg_d2;
   logic [7:0] rt_byte;

   midi_parser #(.CHANNEL(CHANNEL), .NOTE_ON_ZERO_OFF(NOTE_ON_ZERO_OFF)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .dv(dv), .di(di),
      .msg_valid(msg_valid), .msg_cmd(msg_cmd), .msg_ch(msg_ch),
      .msg_d1(msg_d1), .msg_d2(msg_d2), .rt_valid(rt_valid), .rt_byte(rt_byte)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_msgs  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: running status as an int (-1 = none) plus a queue of pending data bytes.
   int         rs = -1;
   logic [6:0] dq[$];
   logic       e_mv = 0, e_rv = 0;
   logic [2:0] e_cmd = 0;
   logic [3:0] e_ch = 0;
   logic [6:0] e_d1 = 0, e_d2 = 0;
   logic [7:0] e_rb = 0;

   task automatic model_reset();
      rs = -1;
      dq.delete();
      e_mv = 0; e_rv = 0; e_cmd = 0; e_ch = 0; e_d1 = 0; e_d2 = 0; e_rb = 0;
   endtask

   task automatic model_byte(input logic acc, input logic [7:0] b);
      int need, cmd, ch, d2;
      e_mv = 0;
      e_rv = 0;
      if (!acc) return;
      if (b >= 8'hF8) begin
         e_rv = 1;
         e_rb = b;
      end else if (b < 8'h80) begin
         if (rs < 0) return;
         dq.push_back(b[6:0]);
         need = ((rs >> 4) == 'hC || (rs >> 4) == 'hD) ? 1 : 2;
         if (dq.size() == need) begin
            cmd = (rs >> 4) & 7;
            ch  = rs & 15;
            d2  = (need == 2) ? int'(dq[1]) : 0;
            if (NOTE_ON_ZERO_OFF != 0 && cmd == 1 && d2 == 0) cmd = 0;
`ifdef MIDI_CHANNEL_FILTER_EN
            if (ch != CHANNEL) begin
               dq.delete();
               return;
            end
`endif
            e_mv  = 1;
            e_cmd = 3'(cmd);
            e_ch  = 4'(ch);
            e_d1  = dq[0];
            e_d2  = 7'(d2);
            dq.delete();
         end
      end else if (b < 8'hF0) begin
         rs = int'(b);
         dq.delete();
      end else begin
         rs = -1;
         dq.delete();
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".mv"},  msg_valid, e_mv);
      check({tag, ".cmd"}, msg_cmd,   e_cmd);
      check({tag, ".ch"},  msg_ch,    e_ch);
      check({tag, ".d1"},  msg_d1,    e_d1);
      check({tag, ".d2"},  msg_d2,    e_d2);
      check({tag, ".rv"},  rt_valid,  e_rv);
      check({tag, ".rb"},  rt_byte,   e_rb);
      if (msg_valid) n_msgs++;
   endtask

   // Called at a falling edge; drives one cycle and checks at the next falling edge.
   task automatic step(input string tag, input logic v, input logic e, input logic [7:0] b);
      dv = v; ce = e; di = b;
      @(negedge clk);
      dv = 0;
      model_byte(v & e, b);
      compare_all(tag);
   endtask

   task automatic send_seq(input string tag, input logic [7:0] bytes[$]);
      foreach (bytes[i]) step(tag, 1'b1, 1'b1, bytes[i]);
   endtask

   task automatic pulse_reset(input string tag);
      rst_n = 0;
      #1;
      model_reset();
      compare_all({tag, ".async"});
      @(negedge clk);
      compare_all({tag, ".held"});
      rst_n = 1;
   endtask

   function automatic logic [7:0] rand_byte();
      int r = $urandom_range(0, 99);
      if (r < 50)      return 8'($urandom_range(0, 127));
      else if (r < 72) return 8'($urandom_range(128, 239));
      else if (r < 82) return 8'($urandom_range(248, 255));
      else if (r < 88) return 8'hF0;
      else if (r < 94) return 8'hF7;
      else             return 8'($urandom_range(241, 246));
   endfunction

   initial begin
      int base;
      logic [7:0] b;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst_n = 1;
      @(negedge clk);

      send_seq("note_on", '{8'h90, 8'h3C, 8'h64});
      check("tp_note_on.cmd", msg_cmd, 3'b001);
      check("tp_note_on.d2", msg_d2, 7'h64);
      base = n_msgs;
      send_seq("running", '{8'h3E, 8'h50});
      check("tp_running.d1", msg_d1, 7'h3E);
      check("tp_running.count", n_msgs - base, 1);
      send_seq("vel0", '{8'h93, 8'h40, 8'h00});
      check("tp_vel0.cmd", msg_cmd, 3'b000);
      send_seq("prog", '{8'hC5, 8'h07});
      check("tp_prog.cmd", msg_cmd, 3'b100);
      base = n_msgs;
      send_seq("rt_mix", '{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
      check("tp_rt_mix.count", n_msgs - base, 1);
      check("tp_rt_mix.rb", rt_byte, 8'hFE);
      base = n_msgs;
      send_seq("sysex", '{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h3C, 8'h40});
      check("tp_sysex.count", n_msgs - base, 0);
      send_seq("cc", '{8'hB1, 8'h07, 8'h7F});
      check("tp_cc.ch", msg_ch, 4'd1);
      send_seq("rst_mid", '{8'h90, 8'h3C});
      pulse_reset("rst_mid");
      base = n_msgs;
      send_seq("rst_after", '{8'h64});
      check("tp_rst.count", n_msgs - base, 0);
      base = n_msgs;
      send_seq("filter", '{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64});
`ifdef MIDI_CHANNEL_FILTER_EN
      check("tp_filter.count", n_msgs - base, 1);
`else
      check("tp_filter.count", n_msgs - base, 2);
`endif
      check("tp_filter.ch", msg_ch, 4'd2);

      for (int i = 0; i < 4000; i++) begin
         int r = $urandom_range(0, 99);
         b = rand_byte();
         if (r < 8)       step("rnd_ce0", 1'b1, 1'b0, b);
         else if (r < 15) step("rnd_idle", 1'b0, 1'b1, b);
         else if (r < 16) pulse_reset("rnd_rst");
         else             step("rnd", 1'b1, 1'b1, b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
